// File: rtl/beta_mem_arb_pkg.sv
// Shared definitions for the Beta memory-port arbiter:
// FSM state encoding and the architectural exception vectors.
package beta_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_e;

  localparam logic [31:0] RESET = 32'h8000_0000;
  localparam logic [31:0] ILLOP = 32'h8000_0004;
  localparam logic [31:0] XADR  = 32'h8000_0008;

endpackage

// File: rtl/beta_mem_arb.sv
// Arbitrates the single memory port between instruction fetch and data access.
// Ports: clk/rst_n; if_* fetch side; d_* data side; m_* memory port; fault.
module beta_mem_arb
  import beta_mem_arb_pkg::*;
#(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        fault
);

  localparam int SW = (STARVE_MAX < 1) ? 1
                    : $clog2(STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1
                    : $clog2(TIMEOUT + 1);

  localparam logic [SW-1:0] S_MAX  = SW'(STARVE_MAX);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  arb_state_e state;
  arb_state_e nstate;

  logic [SW-1:0] starve;
  logic [TW-1:0] tcnt;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic          we_q;

  logic busy;
  logic gnt_d;
  logic gnt_i;
  logic ack;
  logic tmo;
  logic done;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  // Next-state logic
  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (gnt_d) begin
          nstate = D_BUSY;
        end else if (gnt_i) begin
          nstate = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (done) begin
          nstate = IDLE;
        end
      end
      default: nstate = IDLE;
    endcase
  end

  // Output / decode logic
  always_comb begin
    busy  = (state != IDLE);
    // Data wins unless fetch has waited through
    // STARVE_MAX consecutive data grants.
    gnt_d = (state == IDLE) && d_req &&
            (!if_req || (starve < S_MAX));
    gnt_i = (state == IDLE) && !gnt_d && if_req;
    ack   = busy && m_ack;
    // m_ack on the last allowed cycle beats the timeout.
    tmo   = busy && !m_ack && (tcnt == T_LAST);
    done  = ack || tmo;

    m_req    = busy;
    m_we     = busy && we_q;
    m_addr   = addr_q;
    m_wdata  = wdata_q;
    if_stall = if_req && !if_valid;
    d_stall  = d_req && !d_valid;
  end

  // Grant capture, counters and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      we_q     <= 1'b0;
      starve   <= '0;
      tcnt     <= '0;
      if_data  <= '0;
      d_rdata  <= '0;
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if_valid <= done && (state == I_BUSY);
      d_valid  <= done && (state == D_BUSY);
      fault    <= tmo;

      if (gnt_d) begin
        addr_q  <= d_addr;
        wdata_q <= d_wdata;
        we_q    <= d_we;
        tcnt    <= '0;
        if (if_req && (starve < S_MAX)) begin
          starve <= starve + SW'(1);
        end
      end else if (gnt_i) begin
        addr_q  <= if_addr;
        wdata_q <= '0;
        we_q    <= 1'b0;
        tcnt    <= '0;
        starve  <= '0;
      end else if (busy && !done) begin
        tcnt <= tcnt + TW'(1);
      end

      if (ack) begin
        if (state == I_BUSY) begin
          if_data <= m_rdata;
        end else if (!we_q) begin
          // Writes leave the last read value in place.
          d_rdata <= m_rdata;
        end
      end else if (tmo) begin
        if (state == I_BUSY) begin
          if_data <= '0;
        end else begin
          d_rdata <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_beta_mem_arb.sv
// Self-checking bench for beta_mem_arb.
// Scoreboard of expected fetch/data results plus a memory responder.
module tb_beta_mem_arb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_data;
  logic        if_valid;
  logic        if_stall;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_stall;
  logic        m_req;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack = 1'b0;
  logic        fault;

  always #5 clk = ~clk;

  beta_mem_arb #(
    .STARVE_MAX(4),
    .TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_data(if_data),
    .if_valid(if_valid),
    .if_stall(if_stall),
    .d_req(d_req),
    .d_we(d_we),
    .d_addr(d_addr),
    .d_wdata(d_wdata),
    .d_rdata(d_rdata),
    .d_valid(d_valid),
    .d_stall(d_stall),
    .m_req(m_req),
    .m_we(m_we),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_ack(m_ack),
    .fault(fault)
  );

  typedef struct {
    logic [31:0] data;
    logic        flt;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  logic [31:0] gq[$];
  logic        gwe[$];
  logic [31:0] gwd[$];
  logic [31:0] mem[logic [31:0]];
  logic [31:0] shadow[logic [31:0]];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_valid = 0;
  int          last_len = 0;
  int          blen = 0;
  bit          ack_on = 1'b1;
  bit          late_ack = 1'b0;
  int          ack_lat = 0;
  logic [31:0] exp_drd = '0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : (a ^ 32'h5A5A_0000);
  endfunction

  function automatic logic [31:0] rd_mem(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : (a ^ 32'h5A5A_0000);
  endfunction

  // Memory responder: acks after ack_lat cycles of m_req.
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(negedge clk);
      if (late_ack) begin
        m_ack   = 1'b1;
        m_rdata = 32'hBAD0_BAD0;
      end else if (!m_req) begin
        rcnt  = 0;
        m_ack = 1'b0;
      end else begin
        if (ack_on && rcnt == ack_lat) begin
          m_ack   = 1'b1;
          m_rdata = m_we ? 32'h0 : rd_mem(m_addr);
          if (m_we) mem[m_addr] = m_wdata;
        end else begin
          m_ack = 1'b0;
        end
        rcnt++;
      end
    end
  end

  // Monitor: grant log, port stability, scoreboard pops.
  initial begin
    logic        pm;
    logic [31:0] ga;
    logic        gw;
    exp_t        e;
    pm = 1'b0;
    ga = '0;
    gw = 1'b0;
    forever begin
      @(negedge clk);
      if (m_req && !pm) begin
        gq.push_back(m_addr);
        gwe.push_back(m_we);
        gwd.push_back(m_wdata);
        ga = m_addr;
        gw = m_we;
      end else if (m_req) begin
        chk("m_addr_hold", m_addr, ga);
        chk("m_we_hold", 32'(m_we), 32'(gw));
      end
      if (m_req) blen++;
      else if (pm) begin
        last_len = blen;
        blen = 0;
      end
      pm = m_req;
      if (if_valid) begin
        n_valid++;
        chk("if_vld_mreq", 32'(m_req), 0);
        chk("if_q_nonempty", 32'(iq.size() > 0), 1);
        if (iq.size() > 0) begin
          e = iq.pop_front();
          chk("if_data", if_data, e.data);
          chk("if_fault", 32'(fault), 32'(e.flt));
        end
      end
      if (d_valid) begin
        n_valid++;
        chk("d_vld_mreq", 32'(m_req), 0);
        chk("d_q_nonempty", 32'(dq.size() > 0), 1);
        if (dq.size() > 0) begin
          e = dq.pop_front();
          chk("d_rdata", d_rdata, e.data);
          chk("d_fault", 32'(fault), 32'(e.flt));
        end
      end
      if (fault && !if_valid && !d_valid)
        chk("fault_stray", 32'(fault), 0);
    end
  end

  task automatic fetch(input logic [31:0] a,
                       input bit flt,
                       output int cyc);
    exp_t e;
    e.flt  = flt;
    e.data = flt ? 32'h0 : rd_model(a);
    iq.push_back(e);
    if_addr = a;
    if_req  = 1'b1;
    cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      cyc++;
      if (if_valid) break;
      if (i == 0) chk("if_stall_hi", 32'(if_stall), 1);
    end
    chk("if_done", 32'(if_valid), 1);
    chk("if_stall_lo", 32'(if_stall), 0);
    if_req = 1'b0;
  endtask

  task automatic dacc(input bit we,
                      input logic [31:0] a,
                      input logic [31:0] wd,
                      input bit flt,
                      input bit keep);
    exp_t e;
    e.flt = flt;
    if (flt) begin
      e.data  = 32'h0;
      exp_drd = 32'h0;
    end else if (we) begin
      e.data    = exp_drd;
      shadow[a] = wd;
    end else begin
      e.data  = rd_model(a);
      exp_drd = e.data;
    end
    dq.push_back(e);
    d_we    = we;
    d_addr  = a;
    d_wdata = wd;
    d_req   = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (d_valid) break;
      if (i == 0) chk("d_stall_hi", 32'(d_stall), 1);
    end
    chk("d_done", 32'(d_valid), 1);
    chk("d_stall_lo", 32'(d_stall), 0);
    if (!keep) begin
      d_req = 1'b0;
      d_we  = 1'b0;
    end
  endtask

  initial begin
    int          cyc;
    int          c2;
    int          nv0;
    logic [31:0] order[6];

    mem[32'h10]    = 32'hC01F_0004;
    shadow[32'h10] = 32'hC01F_0004;

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 0);
    chk("rst_m_we", 32'(m_we), 0);
    chk("rst_if_valid", 32'(if_valid), 0);
    chk("rst_d_valid", 32'(d_valid), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_if_data", if_data, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_m_addr", m_addr, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Fetch with ack one cycle after m_req, then minimum latency
    ack_lat = 1;
    gq.delete(); gwe.delete(); gwd.delete();
    fetch(32'h10, 1'b0, cyc);
    chk("lat_ack1", 32'(cyc), 3);
    chk("ifetch_we", 32'(gwe[0]), 0);
    chk("ifetch_wdata", gwd[0], 0);
    ack_lat = 0;
    fetch(32'h14, 1'b0, cyc);
    chk("lat_min", 32'(cyc), 2);

    // Contention: data write wins, fetch follows
    gq.delete(); gwe.delete(); gwd.delete();
    fork
      fetch(32'h18, 1'b0, c2);
      dacc(1'b1, 32'h100, 32'hDEAD_BEEF, 1'b0, 1'b0);
    join
    chk("cont_ngrant", 32'(gq.size()), 2);
    if (gq.size() >= 2) begin
      chk("cont_g0", gq[0], 32'h100);
      chk("cont_g0_we", 32'(gwe[0]), 1);
      chk("cont_g0_wd", gwd[0], 32'hDEAD_BEEF);
      chk("cont_g1", gq[1], 32'h18);
      chk("cont_g1_we", 32'(gwe[1]), 0);
      chk("cont_g1_wd", gwd[1], 0);
    end

    // Starvation: fetch gets in after exactly four data grants
    gq.delete(); gwe.delete(); gwd.delete();
    order[0] = 32'h100;
    order[1] = 32'h404;
    order[2] = 32'h408;
    order[3] = 32'h40C;
    order[4] = 32'h20;
    order[5] = 32'h408;
    fork
      fetch(32'h20, 1'b0, c2);
      begin
        dacc(1'b0, 32'h100, 32'h0, 1'b0, 1'b1);
        dacc(1'b0, 32'h404, 32'h0, 1'b0, 1'b1);
        dacc(1'b1, 32'h408, 32'h1234_5678, 1'b0, 1'b1);
        dacc(1'b0, 32'h40C, 32'h0, 1'b0, 1'b1);
        dacc(1'b0, 32'h408, 32'h0, 1'b0, 1'b0);
      end
    join
    chk("starve_ngrant", 32'(gq.size()), 6);
    for (int i = 0; i < 6; i++) begin
      if (i < gq.size()) chk("starve_order", gq[i], order[i]);
    end

    // Timeout: no ack ever
    ack_on = 1'b0;
    dacc(1'b0, 32'h200, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("tmo_len", 32'(last_len), 255);

    // Ack on the very last cycle beats the timeout
    ack_on  = 1'b1;
    ack_lat = 254;
    dacc(1'b0, 32'h204, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("tie_len", 32'(last_len), 255);

    // Reset in the middle of a data access
    ack_on = 1'b0;
    d_addr = 32'h300;
    d_we   = 1'b0;
    d_req  = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_mreq", 32'(m_req), 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mreq", 32'(m_req), 0);
    d_req = 1'b0;
    exp_drd = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    nv0 = n_valid;
    @(negedge clk);
    late_ack = 1'b1;
    repeat (2) @(negedge clk);
    late_ack = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_novalid", 32'(n_valid - nv0), 0);
    chk("rst_mreq_idle", 32'(m_req), 0);

    // Recovery after reset
    ack_on  = 1'b1;
    ack_lat = 0;
    fetch(32'h10, 1'b0, cyc);
    chk("post_lat", 32'(cyc), 2);
    dacc(1'b0, 32'h408, 32'h0, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    chk("iq_left", 32'(iq.size()), 0);
    chk("dq_left", 32'(dq.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
